// File: rtl/bsi_pipe.sv
// rtl/bsi_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshake.
// Optional side-band tag carried with each command when BSI_PIPE_TAG_EN is defined.
module bsi_pipe #(
  parameter int W       = 32,
  parameter int SHIFT_W = $clog2(W),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic [W-1:0]       x_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [1:0]         op_i,
`ifdef BSI_PIPE_TAG_EN
  input  logic [TAG_W-1:0]   tag_i,
  output logic [TAG_W-1:0]   tag_o,
`endif
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [W-1:0]       y_o
);

  if (W < 2 || (W & (W - 1)) != 0) begin : g_chk_w
    $error("bsi_pipe: W must be a power of two >= 2");
  end
  if (STAGES < 1 || STAGES > SHIFT_W) begin : g_chk_stages
    $error("bsi_pipe: STAGES must be in 1..SHIFT_W");
  end
  if (TAG_W < 1) begin : g_chk_tag
    $error("bsi_pipe: TAG_W must be >= 1");
  end

  // The last stage has no downstream levels, so it keeps no shift/op copy.
  localparam int NS = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  load_d;
  logic [STAGES-1:0]  in_vld_d;
  logic [W-1:0]       data_q    [STAGES];
  logic [W-1:0]       in_data_d [STAGES];
  logic [W-1:0]       data_d    [STAGES];
  logic [SHIFT_W-1:0] in_sh_d   [STAGES];
  logic [1:0]         in_op_d   [STAGES];
  logic [SHIFT_W-1:0] sh_q      [NS];
  logic [1:0]         op_q      [NS];

  function automatic int lvl_bound(input int s);
    return (s * SHIFT_W + STAGES - 1) / STAGES;
  endfunction

  function automatic logic [W-1:0] shift_lvls(input logic [W-1:0] d,
                                              input logic [SHIFT_W-1:0] sh,
                                              input logic [1:0] op,
                                              input int lo, input int hi);
    logic [W-1:0] r;
    r = d;
    for (int b = 0; b < SHIFT_W; b++) begin
      if (b >= lo && b < hi && sh[b]) begin
        case (op)
          2'b00:   r = r << (1 << b);
          2'b01:   r = r >> (1 << b);
          2'b10:   r = $signed(r) >>> (1 << b);
          default: r = (r << (1 << b)) | (r >> (W - (1 << b)));
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    logic rdy_chain;
    in_vld_d[0]  = in_vld_i;
    in_data_d[0] = x_i;
    in_sh_d[0]   = shift_i;
    in_op_d[0]   = op_i;
    for (int s = 1; s < STAGES; s++) begin
      in_vld_d[s]  = vld_q[s-1];
      in_data_d[s] = data_q[s-1];
      in_sh_d[s]   = sh_q[s-1];
      in_op_d[s]   = op_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = shift_lvls(in_data_d[s], in_sh_d[s], in_op_d[s],
                             lvl_bound(s), lvl_bound(s + 1));
    end
    // A stage loads when empty or when its successor is taking its content.
    rdy_chain = out_rdy_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      load_d[s] = !vld_q[s] || rdy_chain;
      rdy_chain = load_d[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load_d[s]) begin
          vld_q[s]  <= in_vld_d[s];
          data_q[s] <= data_d[s];
        end
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        if (load_d[s]) begin
          sh_q[s] <= in_sh_d[s];
          op_q[s] <= in_op_d[s];
        end
      end
    end
  end

`ifdef BSI_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q    [STAGES];
  logic [TAG_W-1:0] in_tag_d [STAGES];

  always_comb begin
    in_tag_d[0] = tag_i;
    for (int s = 1; s < STAGES; s++) begin
      in_tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) begin
        if (load_d[s]) begin
          tag_q[s] <= in_tag_d[s];
        end
      end
    end
  end

  assign tag_o = tag_q[STAGES-1];
`endif

  assign in_rdy_o  = load_d[0];
  assign out_vld_o = vld_q[STAGES-1];
  assign y_o       = data_q[STAGES-1];

endmodule

// File: tb/tb_bsi_pipe.sv
// tb/tb_bsi_pipe.sv - directed self-checking bench for bsi_pipe (W=32, STAGES=2).
// Tag ordering checks are built when BSI_PIPE_TAG_EN is defined.
module tb_bsi_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] x;
  logic [4:0]  sh;
  logic [1:0]  op;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] y;
`ifdef BSI_PIPE_TAG_EN
  logic [3:0]  tag_i;
  logic [3:0]  tag_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsi_pipe #(.W(32), .STAGES(2), .TAG_W(4)) dut (
`ifdef BSI_PIPE_TAG_EN
    .tag_i    (tag_i),
    .tag_o    (tag_o),
`endif
    .clk      (clk),
    .rst      (rst),
    .in_vld_i (in_vld),
    .in_rdy_o (in_rdy),
    .x_i      (x),
    .shift_i  (sh),
    .op_i     (op),
    .out_vld_o(out_vld),
    .out_rdy_i(out_rdy),
    .y_o      (y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] xv, input logic [4:0] s,
                       input logic [1:0] o);
    in_vld = v;
    x      = xv;
    sh     = s;
    op     = o;
  endtask

  typedef struct {
    logic [31:0] xv;
    logic [4:0]  s;
    logic [1:0]  o;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [10] = '{
    '{32'h00000001, 5'd31, 2'b00, 32'h80000000},
    '{32'h80000000, 5'd4,  2'b10, 32'hF8000000},
    '{32'h80000000, 5'd4,  2'b01, 32'h08000000},
    '{32'h80000001, 5'd1,  2'b11, 32'h00000003},
    '{32'h80000001, 5'd0,  2'b11, 32'h80000001},
    '{32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF},
    '{32'h7FFFFFF0, 5'd4,  2'b10, 32'h07FFFFFF},
    '{32'h12345678, 5'd8,  2'b11, 32'h34567812},
    '{32'hFFFFFFFF, 5'd31, 2'b01, 32'h00000001},
    '{32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF}
  };

  initial begin
`ifdef BSI_PIPE_TAG_EN
    tag_i = '0;
`endif
    rst     = 1'b1;
    out_rdy = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_out_vld", 32'(out_vld), 32'd0);
    check("reset_in_rdy", 32'(in_rdy), 32'd1);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].xv, vecs[i].s, vecs[i].o);
      #1;
      check($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'd1);
      tick();
      drive(1'b0, 32'h0, 5'd0, 2'b00);
      check($sformatf("vec%0d_lat1_vld", i), 32'(out_vld), 32'd0);
      tick();
      check($sformatf("vec%0d_lat2_vld", i), 32'(out_vld), 32'd1);
      check($sformatf("vec%0d_y", i), y, vecs[i].e);
      tick();
    end

    // Backpressure: two accepts fill the pipe, third waits for release.
    out_rdy = 1'b0;
    drive(1'b1, 32'd1, 5'd1, 2'b00);
    #1;
    check("bp_acc1", 32'(in_rdy), 32'd1);
    tick();
    drive(1'b1, 32'd2, 5'd1, 2'b00);
    #1;
    check("bp_acc2", 32'(in_rdy), 32'd1);
    tick();
    drive(1'b1, 32'd3, 5'd1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_full_rdy", 32'(in_rdy), 32'd0);
      check("bp_hold_vld", 32'(out_vld), 32'd1);
      check("bp_hold_y", y, 32'h2);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    check("bp_full_drain_rdy", 32'(in_rdy), 32'd1);
    check("bp_out0", y, 32'h2);
    tick();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    check("bp_out1_vld", 32'(out_vld), 32'd1);
    check("bp_out1", y, 32'h4);
    tick();
    check("bp_out2_vld", 32'(out_vld), 32'd1);
    check("bp_out2", y, 32'h6);
    tick();
    check("bp_empty", 32'(out_vld), 32'd0);

    // Reset with two commands in flight; the command offered during reset is dropped.
    out_rdy = 1'b0;
    drive(1'b1, 32'd5, 5'd0, 2'b00);
    tick();
    drive(1'b1, 32'd6, 5'd0, 2'b00);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'hAA, 5'd0, 2'b00);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #1;
    check("rst_flight_vld", 32'(out_vld), 32'd0);
    check("rst_flight_rdy", 32'(in_rdy), 32'd1);
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_stale", 32'(out_vld), 32'd0);
    end

    // Back-to-back throughput with out_rdy held high.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 32'd1, 5'(i), 2'b00);
      else       drive(1'b0, 32'h0, 5'd0, 2'b00);
      #1;
      if (i < 4) check("tp_in_rdy", 32'(in_rdy), 32'd1);
      if (i >= 2 && i < 6) begin
        check("tp_vld", 32'(out_vld), 32'd1);
        check("tp_y", y, 32'(1) << (i - 2));
      end else begin
        check("tp_idle", 32'(out_vld), 32'd0);
      end
      tick();
    end

`ifdef BSI_PIPE_TAG_EN
    begin
      int sent;
      int recv;
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
        out_rdy = 1'($urandom_range(0, 1));
        if (sent < 8) begin
          drive(1'b1, 32'(sent), 5'(sent), 2'b00);
          tag_i = 4'(sent);
        end else begin
          drive(1'b0, 32'h0, 5'd0, 2'b00);
        end
        #1;
        if (out_vld && out_rdy) begin
          check("tag_seq", 32'(tag_o), 32'(recv));
          check("tag_y", y, 32'(recv << recv));
          recv++;
        end
        if (in_vld && in_rdy) sent++;
        tick();
      end
      check("tag_all_received", 32'(recv), 32'd8);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
